// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor, one bit per clock, LSB first.
// Operands are latched on start; the result and carry register update only on
// the completion edge and hold until the next completion.
// Optional feature: define OVERFLOW_FLAG_EN to add the signed-overflow output ovf_o.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             select_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
`ifdef OVERFLOW_FLAG_EN
    output logic             ovf_o,
`endif
    output logic             carry_o
);

    // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;       // operand A, shifted right one bit per cycle
    logic [WIDTH-1:0] b_q;       // operand B (already inverted for subtract), shifted likewise
    logic             sel_q;     // latched mode, decides carry vs. borrow polarity
    logic             c_q;       // running carry, preset to select so subtract gets its +1
    logic [WIDTH-1:0] sr_q;      // sum bits enter at the MSB end and walk down
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
`ifdef OVERFLOW_FLAG_EN
    logic             ovf_q;
`endif

    logic             sum_bit;
    logic             cout;
    logic             last_bit;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] sr_d;

    // One full-adder slice on the current LSBs plus the shifted next values.
    always_comb begin
        sum_bit  = a_q[0] ^ b_q[0] ^ c_q;
        cout     = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        last_bit = (cnt_q == CW'(WIDTH - 1));
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        sr_d     = (sr_q >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
    end

    // Control FSM with registered outputs; reset overrides everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= 1'b0;
            c_q      <= 1'b0;
            sr_q     <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        // Subtract is A + ~B + 1: invert B now, the +1 is the carry preset.
                        a_q     <= a_i;
                        b_q     <= select_i ? ~b_i : b_i;
                        sel_q   <= select_i;
                        c_q     <= select_i;
                        sr_q    <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    c_q   <= cout;
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_bit) begin
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= sr_d;
                        // Final carry of A+~B+1 is "no borrow", so flip it for subtract.
                        carry_q  <= sel_q ? ~cout : cout;
`ifdef OVERFLOW_FLAG_EN
                        // c_q is the carry into the MSB, cout the carry out of it.
                        ovf_q    <= c_q ^ cout;
`endif
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign carry_o  = carry_q;
`ifdef OVERFLOW_FLAG_EN
    assign ovf_o    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: scoreboard bench for serial_add_sub at WIDTH=8 and WIDTH=1.
module tb_serial_add_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, sel8, busy8, done8, carry8;
    logic [7:0] a8, b8, result8;
    logic       start1, sel1, busy1, done1, carry1;
    logic [0:0] a1, b1, result1;
`ifdef OVERFLOW_FLAG_EN
    logic       ovf8, ovf1;
`endif

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8),
        .select_i(sel8), .busy_o(busy8), .done_o(done8), .result_o(result8),
`ifdef OVERFLOW_FLAG_EN
        .ovf_o(ovf8),
`endif
        .carry_o(carry8));

    serial_add_sub #(.WIDTH(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .a_i(a1), .b_i(b1),
        .select_i(sel1), .busy_o(busy1), .done_o(done1), .result_o(result1),
`ifdef OVERFLOW_FLAG_EN
        .ovf_o(ovf1),
`endif
        .carry_o(carry1));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       v;
        int         t;   // cyc value at the negedge where done must be seen
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    exp_t m8, m1;

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic exp_t model(int w, logic [7:0] a, logic [7:0] b, logic sel, int t);
        exp_t e;
        longint unsigned mask = (64'd1 << w) - 1;
        longint unsigned ua = a & mask;
        longint unsigned ub = b & mask;
        longint unsigned s;
        logic sa, sb, sr;
        if (!sel) begin
            s   = ua + ub;
            e.c = ((s >> w) & 1) != 0;
        end else begin
            s   = ua - ub;
            e.c = (ua < ub);
        end
        e.res = 8'(s & mask);
        sa = ((ua >> (w - 1)) & 1) != 0;
        sb = ((ub >> (w - 1)) & 1) != 0;
        sr = ((s  >> (w - 1)) & 1) != 0;
        e.v = sel ? (sa != sb) && (sr != sa) : (sa == sb) && (sr != sa);
        e.t = t;
        return e;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL done8_spurious: got done with no pending op (cyc %0d)", cyc);
            end else begin
                m8 = q8.pop_front();
                check("result8", result8, m8.res);
                check("carry8", carry8, m8.c);
`ifdef OVERFLOW_FLAG_EN
                check("ovf8", ovf8, m8.v);
`endif
                check("done8_time", cyc, m8.t);
                check("busy8_at_done", busy8, 0);
            end
        end
    end

    // Monitor for the 1-bit instance.
    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL done1_spurious: got done with no pending op (cyc %0d)", cyc);
            end else begin
                m1 = q1.pop_front();
                check("result1", result1, m1.res[0]);
                check("carry1", carry1, m1.c);
`ifdef OVERFLOW_FLAG_EN
                check("ovf1", ovf1, m1.v);
`endif
                check("done1_time", cyc, m1.t);
                check("busy1_at_done", busy1, 0);
            end
        end
    end

    // Caller is at a negedge with dut8 idle or in DONE; returns one negedge later.
    task automatic issue8(logic [7:0] a, logic [7:0] b, logic sel, bit push);
        a8 = a; b8 = b; sel8 = sel; start8 = 1'b1;
        if (push) q8.push_back(model(8, a, b, sel, cyc + 1 + 8));
        @(negedge clk);
        start8 = 1'b0;
        check("busy8_after_start", busy8, 1);
    endtask

    // Scramble inputs while waiting so latched operands are exercised; bounded.
    task automatic wait8();
        int n = 0;
        while (done8 !== 1'b1 && n < 20) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sel8 = 1'($urandom);
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL wait8_timeout: got no done within %0d cycles", n);
        end
    endtask

    task automatic issue1(logic a, logic b, logic sel);
        a1 = a; b1 = b; sel1 = sel; start1 = 1'b1;
        q1.push_back(model(1, {7'd0, a}, {7'd0, b}, sel, cyc + 1 + 1));
        @(negedge clk);
        start1 = 1'b0;
        check("busy1_after_start", busy1, 1);
    endtask

    task automatic wait1();
        int n = 0;
        while (done1 !== 1'b1 && n < 8) begin
            a1 = 1'($urandom); b1 = 1'($urandom); sel1 = 1'($urandom);
            @(negedge clk);
            n++;
        end
        if (n >= 8) begin
            total++; bad++;
            $display("FAIL wait1_timeout: got no done within %0d cycles", n);
        end
    endtask

    initial begin
        // Reset with random inputs and start asserted.
        rst = 1'b1;
        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); sel8 = 1'($urandom);
        start1 = 1'b1; a1 = 1'($urandom); b1 = 1'($urandom); sel1 = 1'($urandom);
        repeat (2) @(negedge clk);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_result8", result8, 0);
        check("rst_carry8", carry8, 0);
        check("rst_busy1", busy1, 0);
        check("rst_result1", result1, 0);
`ifdef OVERFLOW_FLAG_EN
        check("rst_ovf8", ovf8, 0);
`endif
        rst = 1'b0; start8 = 1'b0; start1 = 1'b0;
        @(negedge clk);

        // Directed cases.
        issue8(8'h3C, 8'h0F, 1'b0, 1); wait8(); @(negedge clk);
        issue8(8'hFF, 8'h01, 1'b0, 1); wait8(); @(negedge clk);
        issue8(8'h05, 8'h07, 1'b1, 1); wait8(); @(negedge clk);
        issue8(8'h80, 8'h01, 1'b1, 1); wait8(); @(negedge clk);
        issue8(8'h7F, 8'h01, 1'b0, 1); wait8(); @(negedge clk);

        // start pulsed mid-RUN must be ignored.
        issue8(8'h12, 8'h34, 1'b0, 1);
        repeat (2) @(negedge clk);
        a8 = 8'hAA; b8 = 8'hBB; sel8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait8();

        // Back-to-back: start while in DONE.
        issue8(8'h55, 8'hAA, 1'b1, 1); wait8();
        issue8(8'hC8, 8'h64, 1'b0, 1); wait8(); @(negedge clk);

        // Reset while processing bit 4: no done, outputs cleared.
        issue8(8'h9A, 8'h21, 1'b0, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy8", busy8, 0);
        check("abort_done8", done8, 0);
        check("abort_result8", result8, 0);
        check("abort_carry8", carry8, 0);
`ifdef OVERFLOW_FLAG_EN
        check("abort_ovf8", ovf8, 0);
`endif
        repeat (10) @(negedge clk);
        issue8(8'h3C, 8'h0F, 1'b0, 1); wait8(); @(negedge clk);

        // Random operations, sometimes back-to-back.
        for (int i = 0; i < 40; i++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom), 1);
            wait8();
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        @(negedge clk);

        // WIDTH=1 truth table, then a few back-to-back random ones.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            issue1(v[2], v[1], v[0]);
            wait1();
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            issue1(1'($urandom), 1'($urandom), 1'($urandom));
            wait1();
        end
        repeat (3) @(negedge clk);

        if (q8.size() != 0 || q1.size() != 0) begin
            total++; bad++;
            $display("FAIL pending_ops: got %0d/%0d left expected 0/0", q8.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
